// File: rtl/adder_arbiter_if.sv
// Request/result bundle for adder_arbiter: two operand requesters,
// one result consumer, and the per-requester completion counters.
interface adder_arbiter_if #(
    parameter int N = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_cin;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        input  cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        output cnt0, cnt1
    );
endinterface

// File: rtl/adder_arbiter.sv
// Two requesters sharing one N-bit adder with a registered result stage.
// Define ADDER_ARB_RR_EN for round-robin grant; default is fixed priority to req0.
module adder_arbiter #(
    parameter int N = 8
) (
    input logic            clk,
    input logic            rst_n,
    adder_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t       state;
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         id_q;
    logic [7:0]   cnt0_q;
    logic [7:0]   cnt1_q;
    logic         pick1;
    logic         idle;
    logic         take;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         op_cin;
    logic [N:0]   total;

`ifdef ADDER_ARB_RR_EN
    logic last_grant;
    // On contention, req1 wins only if req0 was the last one served.
    assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
`else
    assign pick1 = bus.req1_valid && !bus.req0_valid;
`endif

    assign idle = rst_n && (state == IDLE);
    assign bus.req0_ready = idle && bus.req0_valid && !pick1;
    assign bus.req1_ready = idle && pick1;
    assign take = bus.req0_ready || bus.req1_ready;

    assign op_a   = pick1 ? bus.req1_a   : bus.req0_a;
    assign op_b   = pick1 ? bus.req1_b   : bus.req0_b;
    assign op_cin = pick1 ? bus.req1_cin : bus.req0_cin;
    assign total  = {1'b0, op_a} + {1'b0, op_b} + {{N{1'b0}}, op_cin};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sum_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= 1'b0;
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
`ifdef ADDER_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        sum_q  <= total[N-1:0];
                        cout_q <= total[N];
                        id_q   <= pick1;
                        state  <= RESP;
`ifdef ADDER_ARB_RR_EN
                        last_grant <= pick1;
`endif
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                        if (id_q) cnt1_q <= cnt1_q + 8'd1;
                        else      cnt0_q <= cnt0_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.res_valid = (state == RESP);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign bus.res_id    = id_q;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a
// transaction-level model of grants, sums and completion counts.
module tb_adder_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    adder_arbiter_if #(.N(N)) bus ();

    adder_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int pass = 0;

    // model state
    bit       m_busy = 0;
    int       m_sum = 0;
    int       m_cout = 0;
    int       m_id = 0;
    int       m_cnt0 = 0;
    int       m_cnt1 = 0;
    int       m_last = 1;
    bit       e_rdy0, e_rdy1;
    logic     o_rdy0, o_rdy1;

    task automatic clear_inputs;
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
        bus.res_ready = 0;
    endtask

    // One clock: predict grant, sample ready mid-cycle, apply edge to model.
    task automatic step;
        int s;
        @(negedge clk);
        e_rdy0 = 0;
        e_rdy1 = 0;
        if (rst_n && !m_busy) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef ADDER_ARB_RR_EN
                if (m_last == 1) e_rdy0 = 1;
                else e_rdy1 = 1;
`else
                e_rdy0 = 1;
`endif
            end else if (bus.req0_valid) e_rdy0 = 1;
            else if (bus.req1_valid) e_rdy1 = 1;
        end
        #1;
        o_rdy0 = bus.req0_ready;
        o_rdy1 = bus.req1_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_sum = 0; m_cout = 0; m_id = 0;
            m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
        end else if (m_busy) begin
            if (bus.res_ready) begin
                m_busy = 0;
                if (m_id == 1) m_cnt1 = (m_cnt1 + 1) % 256;
                else m_cnt0 = (m_cnt0 + 1) % 256;
            end
        end else if (e_rdy0 || e_rdy1) begin
            if (e_rdy1) s = int'(bus.req1_a) + int'(bus.req1_b) + int'(bus.req1_cin);
            else s = int'(bus.req0_a) + int'(bus.req0_b) + int'(bus.req0_cin);
            m_sum = s % 256;
            m_cout = s / 256;
            m_id = e_rdy1 ? 1 : 0;
            m_last = m_id;
            m_busy = 1;
        end
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        rst_n = 0;
        step();
        step();
        chk++; if (o_rdy0 !== 1'b0 || o_rdy1 !== 1'b0)
            $display("FAIL reset_ready got %b%b want 00", o_rdy0, o_rdy1); else pass++;
        chk++; if (bus.res_valid !== 1'b0)
            $display("FAIL reset_valid got %b want 0", bus.res_valid); else pass++;
        chk++; if (bus.res_sum !== 8'h00 || bus.res_cout !== 1'b0 || bus.res_id !== 1'b0)
            $display("FAIL reset_res got %h/%b/%b want 00/0/0",
                     bus.res_sum, bus.res_cout, bus.res_id); else pass++;
        chk++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0)
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); else pass++;
        clear_inputs();
        rst_n = 1;
    endtask

    task automatic test_req0;
        bus.req0_valid = 1; bus.req0_a = 8'h0F; bus.req0_b = 8'h01; bus.req0_cin = 0;
        bus.res_ready = 1;
        step();
        chk++; if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0)
            $display("FAIL req0_grant got %b%b want 10", o_rdy0, o_rdy1); else pass++;
        chk++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h10 ||
                   bus.res_cout !== 1'b0 || bus.res_id !== 1'b0)
            $display("FAIL req0_result got %b/%h/%b/%b want 1/10/0/0", bus.res_valid,
                     bus.res_sum, bus.res_cout, bus.res_id); else pass++;
        step();
        chk++; if (o_rdy0 !== 1'b0)
            $display("FAIL req0_no_accept_on_handoff got %b want 0", o_rdy0); else pass++;
        chk++; if (bus.res_valid !== 1'b0 || bus.cnt0 !== 8'd1)
            $display("FAIL req0_handoff got %b/%0d want 0/1", bus.res_valid, bus.cnt0); else pass++;
        clear_inputs();
    endtask

    task automatic test_req1;
        bus.req1_valid = 1; bus.req1_a = 8'hFF; bus.req1_b = 8'h01; bus.req1_cin = 0;
        bus.req0_a = 8'h33; bus.req0_b = 8'h44;
        bus.res_ready = 1;
        step();
        bus.req1_valid = 0;
        chk++; if (o_rdy1 !== 1'b1 || o_rdy0 !== 1'b0)
            $display("FAIL req1_grant got %b%b want 01", o_rdy0, o_rdy1); else pass++;
        chk++; if (bus.res_sum !== 8'h00 || bus.res_cout !== 1'b1 || bus.res_id !== 1'b1)
            $display("FAIL req1_result got %h/%b/%b want 00/1/1",
                     bus.res_sum, bus.res_cout, bus.res_id); else pass++;
        step();
        chk++; if (bus.cnt1 !== 8'd1 || bus.cnt0 !== 8'd1)
            $display("FAIL req1_cnt got %0d/%0d want 1/1", bus.cnt0, bus.cnt1); else pass++;
        clear_inputs();
    endtask

    task automatic test_backpressure;
        bus.req0_valid = 1; bus.req0_a = 8'hAA; bus.req0_b = 8'h55; bus.req0_cin = 1;
        bus.res_ready = 0;
        step();
        bus.req1_valid = 1;
        bus.req1_a = 8'h12;
        for (int i = 0; i < 5; i++) begin
            step();
            chk++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 8'h00 ||
                       bus.res_cout !== 1'b1 || bus.res_id !== 1'b0)
                $display("FAIL bp_hold[%0d] got %b/%h/%b/%b want 1/00/1/0", i, bus.res_valid,
                         bus.res_sum, bus.res_cout, bus.res_id); else pass++;
            chk++; if (o_rdy0 !== 1'b0 || o_rdy1 !== 1'b0)
                $display("FAIL bp_ready[%0d] got %b%b want 00", i, o_rdy0, o_rdy1); else pass++;
            chk++; if (bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd1)
                $display("FAIL bp_cnt[%0d] got %0d/%0d want 1/1", i, bus.cnt0, bus.cnt1); else pass++;
        end
        clear_inputs();
        bus.res_ready = 1;
        step();
        chk++; if (bus.res_valid !== 1'b0 || bus.cnt0 !== 8'd2)
            $display("FAIL bp_release got %b/%0d want 0/2", bus.res_valid, bus.cnt0); else pass++;
        clear_inputs();
    endtask

    task automatic test_arbitration;
        int exp_id[4];
`ifdef ADDER_ARB_RR_EN
        exp_id = '{0, 1, 0, 1};
`else
        exp_id = '{0, 0, 0, 0};
`endif
        rst_n = 0;
        step();
        rst_n = 1;
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        bus.res_ready = 1;
        for (int i = 0; i < 8; i++) begin
            bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_cin = 1'($urandom);
            bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_cin = 1'($urandom);
            step();
            if (i % 2 == 0) begin
                chk++; if (bus.res_id !== 1'(exp_id[i/2]))
                    $display("FAIL arb_id[%0d] got %0d want %0d", i/2, bus.res_id, exp_id[i/2]);
                else pass++;
                chk++; if (bus.res_sum !== 8'(m_sum) || bus.res_cout !== 1'(m_cout))
                    $display("FAIL arb_sum[%0d] got %h/%b want %h/%0d", i/2,
                             bus.res_sum, bus.res_cout, m_sum, m_cout); else pass++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_cin = 1'($urandom);
            bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_cin = 1'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            step();
            chk++; if (o_rdy0 !== e_rdy0 || o_rdy1 !== e_rdy1)
                $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, o_rdy0, o_rdy1,
                         e_rdy0, e_rdy1); else pass++;
            chk++; if (bus.res_valid !== m_busy)
                $display("FAIL rnd_valid[%0d] got %b want %b", i, bus.res_valid, m_busy); else pass++;
            if (m_busy) begin
                chk++; if (bus.res_sum !== 8'(m_sum) || bus.res_cout !== 1'(m_cout) ||
                           bus.res_id !== 1'(m_id))
                    $display("FAIL rnd_res[%0d] got %h/%b/%b want %h/%0d/%0d", i, bus.res_sum,
                             bus.res_cout, bus.res_id, m_sum, m_cout, m_id); else pass++;
            end
            chk++; if (bus.cnt0 !== 8'(m_cnt0) || bus.cnt1 !== 8'(m_cnt1))
                $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, bus.cnt0, bus.cnt1,
                         m_cnt0, m_cnt1); else pass++;
        end
        clear_inputs();
    endtask

    task automatic test_wrap_and_reset;
        rst_n = 0;
        step();
        rst_n = 1;
        bus.req0_valid = 1;
        bus.res_ready = 1;
        for (int i = 0; i < 510; i++) begin
            bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
            step();
        end
        chk++; if (bus.cnt0 !== 8'd255)
            $display("FAIL wrap_255 got %0d want 255", bus.cnt0); else pass++;
        step();
        step();
        chk++; if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0)
            $display("FAIL wrap_0 got %0d/%0d want 0/0", bus.cnt0, bus.cnt1); else pass++;
        step();
        chk++; if (bus.res_valid !== 1'b1)
            $display("FAIL midop_accept got %b want 1", bus.res_valid); else pass++;
        rst_n = 0;
        step();
        chk++; if (o_rdy0 !== 1'b0)
            $display("FAIL midop_ready got %b want 0", o_rdy0); else pass++;
        chk++; if (bus.res_valid !== 1'b0 || bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0)
            $display("FAIL midop_reset got %b/%0d/%0d want 0/0/0",
                     bus.res_valid, bus.cnt0, bus.cnt1); else pass++;
        clear_inputs();
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_req0();
        test_req1();
        test_backpressure();
        test_arbitration();
        test_random();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N, default 8, operand and sum width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 req0_valid  input  1  requester 0 has an operation pending; req0_a/req0_b (input, N) operands; req0_cin (input, 1) carry-in.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req1_valid, req1_a, req1_b, req1_cin  input  1/N/N/1  requester 1, identical meaning to requester 0.
REQ-007 req1_ready  output  1  requester 1 operation accepted this cycle.
REQ-008 res_valid  output  1  result registers hold a valid result.
REQ-009 res_ready  input  1  consumer accepts the result this cycle.
REQ-010 res_sum  output  N  registered sum; res_cout  output  1  registered carry-out; res_id  output  1  index of the requester that issued the result.
REQ-011 cnt0, cnt1  output  8 each  completed-transaction counters for requester 0 and requester 1.

Function
REQ-012 The block SHALL share a single N-bit adder computing {cout,sum} = a + b + cin at N+1 bits between two requesters.
REQ-013 The FSM SHALL have two states, IDLE and RESP.
REQ-014 In IDLE, the block SHALL assert exactly one reqX_ready, combinationally, for the granted requester when at least one reqX_valid is high; otherwise both ready outputs SHALL be low.
REQ-015 A transfer SHALL occur on an edge where reqX_valid and reqX_ready are both high: operands are added, and sum, cout and id are registered; the FSM moves to RESP; res_valid is high from that edge onward (1-cycle latency).
REQ-016 In RESP, both reqX_ready outputs SHALL be low and res_sum/res_cout/res_id SHALL be held stable.
REQ-017 On an edge with res_valid and res_ready both high, the block SHALL return to IDLE, clear res_valid, and increment cnt[res_id] by 1 with modulo-256 wrap (255 -> 0).
REQ-018 Maximum throughput SHALL be one operation per two cycles; acceptance of a new request in the same cycle as result handoff SHALL NOT occur.
REQ-019 When only one requester is valid, that requester SHALL be granted regardless of arbitration history.
REQ-020 When both requesters are valid, the grant SHALL follow the arbitration policy in REQ-026/REQ-027.
REQ-021 A requester dropping valid before being granted SHALL NOT cause a transfer or affect the counters.
REQ-022 Operand values on the non-granted requester SHALL have no effect on any output.

Reset
REQ-023 While rst_n is low at a rising edge, the block SHALL force: state=IDLE; res_valid=0; res_sum=0; res_cout=0; res_id=0; cnt0=0; cnt1=0; last-grant register=1.
REQ-024 Reset asserted in RESP SHALL discard the pending result without incrementing any counter; res_valid SHALL be low after that edge.
REQ-025 While rst_n is low, req0_ready and req1_ready SHALL be low.

Configuration
REQ-026 With macro ADDER_ARB_RR_EN defined, when both are valid the block SHALL grant the requester not granted last; the last-grant register SHALL update on every transfer.
REQ-027 Without ADDER_ARB_RR_EN, when both are valid the block SHALL always grant requester 0 (fixed priority); the last-grant register SHALL be absent or unused.

Verification (N=8)
REQ-028 Reset: hold rst_n=0 for 2 cycles -> res_valid=0, res_sum=0x00, res_cout=0, res_id=0, cnt0=cnt1=0, both ready low.
REQ-029 req0 only with a=0x0F, b=0x01, cin=0, res_ready=1 -> req0_ready=1 in the request cycle; next cycle res_valid=1, res_sum=0x10, res_cout=0, res_id=0; cnt0=1 after handoff.
REQ-030 req1 only with a=0xFF, b=0x01, cin=0 -> res_sum=0x00, res_cout=1, res_id=1; cnt1 increments to 1.
REQ-031 Backpressure: req0 a=0xAA, b=0x55, cin=1, res_ready=0 for 5 cycles -> res_valid stays 1, res_sum=0x00, res_cout=1 stable, both ready low, counters unchanged; res_ready=1 -> IDLE next cycle, cnt0 increments.
REQ-032 Both valid continuously with res_ready=1, 4 operations -> with ADDER_ARB_RR_EN res_id sequence 0,1,0,1; without it 0,0,0,0.
REQ-033 Counter wrap and reset mid-op: 256 req0 transactions -> cnt0 returns to 0; then rst_n=0 during RESP -> res_valid=0 next cycle, counters 0, no increment.
